// File: rtl/shift_two_rx.sv
// shift_two_rx: receive-side symbol assembler for the PPM link.
// It collects four LSB-first 2-bit symbols from the PPM demodulator and
// rebuilds the original byte. If the symbol stream stalls or is flushed,
// it discards the partial byte and pulses frame_err.
module shift_two_rx #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  input  logic       flush,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  // The state name is the number of symbols of the current byte held so far.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } state_t;

  // Gap counter value on which a missing strobe expires the partial byte.
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [5:0]       held, held_nxt;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [7:0]       data_out_nxt;
  logic             data_valid_nxt;
  logic             frame_err_nxt;

  // Register all state and outputs. Reset wins over every other input and
  // drops any partial byte without raising frame_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      held       <= '0;
      gap_cnt    <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      held       <= held_nxt;
      gap_cnt    <= gap_cnt_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  // Next-state logic. Inside a byte, flush has the highest priority, then an
  // accepted symbol, then timeout expiry. A symbol that arrives on the expiry
  // cycle therefore still counts. In IDLE, flush is ignored and the gap
  // counter stays at zero.
  always_comb begin
    state_nxt      = state;
    held_nxt       = held;
    gap_cnt_nxt    = gap_cnt;
    data_out_nxt   = data_out;
    data_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;

    if (state == IDLE) begin
      gap_cnt_nxt = '0;
      if (sym_valid) begin
        held_nxt  = {4'b0000, sym_in};
        state_nxt = S1;
      end
    end else if (flush) begin
      state_nxt     = IDLE;
      held_nxt      = '0;
      gap_cnt_nxt   = '0;
      frame_err_nxt = 1'b1;
    end else if (sym_valid) begin
      gap_cnt_nxt = '0;
      case (state)
        S1: begin
          held_nxt[3:2] = sym_in;
          state_nxt     = S2;
        end
        S2: begin
          held_nxt[5:4] = sym_in;
          state_nxt     = S3;
        end
        default: begin
          data_out_nxt   = {sym_in, held};
          data_valid_nxt = 1'b1;
          held_nxt       = '0;
          state_nxt      = IDLE;
        end
      endcase
    end else if (gap_cnt == LAST_GAP) begin
      state_nxt     = IDLE;
      held_nxt      = '0;
      gap_cnt_nxt   = '0;
      frame_err_nxt = 1'b1;
    end else begin
      gap_cnt_nxt = gap_cnt + 1'b1;
    end
  end

  // busy is high whenever part of a byte is being held.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: doc/shift_two_rx.md
Name: shift_two_rx

Overview:
Receive-side symbol assembler for the PPM link. It collects the 2-bit symbols recovered by the PPM demodulator and rebuilds the 8-bit bytes that the transmitter splits into four LSB-first dibit symbols. A byte is emitted only after all four symbols arrive. A partial byte is discarded, with an error pulse, if the symbol stream stalls or is flushed. Sits between the PPM demodulator and the byte sink (FIFO/UART bridge).

Parameters:
TIMEOUT, 256, max clk cycles allowed between consecutive sym_valid pulses inside one byte (transmitter symbol period is 128; default gives 2x margin); must be >= 2
CNT_W, 9, width of the inter-symbol gap counter; must hold TIMEOUT-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
sym_in  input  2  recovered symbol; sampled only when sym_valid=1
sym_valid  input  1  one-cycle strobe, one per received symbol
flush  input  1  synchronous abort of any partial byte
data_out  output  8  assembled byte; holds its value until the next byte completes
data_valid  output  1  one-cycle pulse when data_out is updated
frame_err  output  1  one-cycle pulse when a partial byte is discarded (timeout or flush)
busy  output  1  high while 1-3 symbols of a byte are held

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, shift register=0, gap counter=0.
  - data_out=8'h00, data_valid=0, frame_err=0, busy=0.
  - Reset overrides every other input, including mid-byte; the partial byte is lost and no frame_err is raised.
- States: IDLE (0 symbols held), S1, S2, S3 (1, 2, 3 symbols held). busy=1 exactly in S1-S3.
- Bit mapping, LSB-first:
  - 1st symbol -> byte[1:0], 2nd -> byte[3:2], 3rd -> byte[5:4], 4th -> byte[7:6].
  - sym_in[0] maps to the lower bit of each pair.
- Transitions on sym_valid=1:
  - IDLE->S1, S1->S2, S2->S3.
  - S3->IDLE with a completed byte.
  - The gap counter clears to 0 on every accepted symbol.
- Byte completion:
  - On the clk edge that samples the 4th sym_valid, data_out <= {sym_in, held[5:0]} and data_valid=1 for exactly that following cycle.
  - Latency: data_valid is high in the cycle after the 4th strobe.
- Back-to-back bytes: a sym_valid in the cycle immediately after completion (state IDLE) starts the next byte normally. data_valid and that acceptance may coincide.
- Gap counter:
  - Increments every cycle in S1-S3 without sym_valid; held at 0 in IDLE.
  - If the counter equals TIMEOUT-1 and sym_valid=0: go to IDLE, clear the shift register, frame_err=1 for one cycle, counter=0.
- sym_valid in the same cycle as timeout expiry: the symbol wins and is accepted; no error.
- flush=1:
  - In S1-S3: go to IDLE, clear the shift register, frame_err=1 for one cycle.
  - In IDLE: no effect and no frame_err.
  - flush has priority over sym_valid in the same cycle; that symbol is dropped, including when it would have been the 4th (no data_valid).
- data_valid and frame_err are never high in the same cycle.
- data_out changes only on completion; it does not change on error or flush.
- sym_in is a don't-care when sym_valid=0.

Test Plan:
1. Reset then 4 strobes spaced 128 cycles with sym_in=2'b01,2'b10,2'b11,2'b00 -> data_valid one cycle after 4th strobe, data_out=8'h39, frame_err never high, busy high from 1st strobe until completion.
2. Two bytes back-to-back at 1-cycle spacing (8'hA5 then 8'h3C split LSB-first) -> two data_valid pulses with correct values; after 2nd, data_out stays 8'h3C for 1000 idle cycles.
3. Two symbols then no strobe -> frame_err pulses exactly TIMEOUT cycles after 2nd strobe, busy falls, data_out unchanged; next 4 symbols (8'hFF) assemble cleanly to 8'hFF.
4. Third symbol strobed in the exact timeout-expiry cycle -> accepted, no frame_err; 4th symbol completes the byte correctly.
5. flush together with the 4th sym_valid -> no data_valid, frame_err=1 one cycle, state IDLE; flush while IDLE -> no frame_err.
6. rst asserted after 3 symbols -> all outputs 0 the next cycle, no frame_err; subsequent byte 8'h81 assembles correctly.
